// File: rtl/reqrsp_xbar_pkg.sv
// Shared types and helpers for the cache request xbar priority scheduler.
package reqrsp_xbar_pkg;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } prio_state_e;

    // A select field is at least one bit wide, even when it has a single target.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reqrsp_xbar_prio_port.sv
// One bank's round-robin pointer and starvation-boost FSM; drives that bank's rr index.
module reqrsp_xbar_prio_port
    import reqrsp_xbar_pkg::*;
#(
    parameter int unsigned NumInp  = 32'd2,
    parameter int unsigned MstSelW = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               i_en,
    input  logic               i_hs,
    input  logic [MstSelW-1:0] i_gnt_idx,
    input  logic [NumInp-1:0]  i_starve_mask,
    input  logic [NumInp-1:0]  i_req_mask,
    output logic [MstSelW-1:0] o_rr,
    output logic               o_starve
);

    prio_state_e        r_state, w_state_next;
    logic [MstSelW-1:0] r_ptr, w_ptr_next;
    logic [MstSelW-1:0] r_boost, w_boost_next;
    logic [MstSelW-1:0] r_rr;
    logic               r_starve;
    logic [MstSelW-1:0] w_lowest;

    function automatic logic [MstSelW-1:0] nxt(input logic [MstSelW-1:0] x);
        if (32'(x) >= NumInp - 1) return '0;
        return x + MstSelW'(1);
    endfunction

    always_comb begin
        w_lowest = '0;
        for (int i = NumInp - 1; i >= 0; i--) begin
            if (i_starve_mask[i]) w_lowest = MstSelW'(i);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_boost_next = r_boost;
        if (i_en) begin
            case (r_state)
                NORMAL: begin
                    if (i_hs) w_ptr_next = nxt(i_gnt_idx);
                    if (|i_starve_mask) begin
                        w_boost_next = w_lowest;
                        w_state_next = BOOST;
                    end
                end
                default: begin
                    // Only the boosted requester's own grant releases the boost.
                    if (i_hs && (i_gnt_idx == r_boost)) begin
                        w_ptr_next   = nxt(r_boost);
                        w_state_next = NORMAL;
                    end else if (!i_req_mask[r_boost]) begin
                        w_state_next = NORMAL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= NORMAL;
            r_ptr    <= '0;
            r_boost  <= '0;
            r_rr     <= '0;
            r_starve <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_boost  <= w_boost_next;
            r_rr     <= (w_state_next == BOOST) ? w_boost_next : w_ptr_next;
            r_starve <= (w_state_next == BOOST);
        end
    end

    assign o_rr     = r_rr;
    assign o_starve = r_starve;

endmodule

// File: rtl/reqrsp_xbar_prio_sched.sv
// External per-bank priority generator for the cache request xbar, with
// per-requester age tracking that boosts long-stalled requesters.
module reqrsp_xbar_prio_sched
    import reqrsp_xbar_pkg::*;
#(
    parameter int unsigned NumInp       = 32'd2,
    parameter int unsigned NumOut       = 32'd2,
    parameter int unsigned StarveThresh = 32'd7,
    localparam int unsigned SlvSelW     = clog2_min1(NumOut),
    localparam int unsigned MstSelW     = clog2_min1(NumInp)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             en_i,
    input  logic [NumInp-1:0]                req_valid_i,
    input  logic [NumInp-1:0]                req_ready_i,
    input  logic [NumInp-1:0][SlvSelW-1:0]   req_sel_i,
    input  logic [NumOut-1:0]                gnt_valid_i,
    input  logic [NumOut-1:0]                gnt_ready_i,
    input  logic [NumOut-1:0][MstSelW-1:0]   gnt_idx_i,
    output logic [NumOut-1:0][MstSelW-1:0]   rr_o,
    output logic [NumOut-1:0]                starve_o
);

    localparam int unsigned  AgeW   = $clog2(StarveThresh + 1);
    localparam logic [AgeW-1:0] AgeMax = AgeW'(StarveThresh);

    logic [NumInp-1:0]              w_starving;
    logic [NumOut-1:0][NumInp-1:0]  w_tgt;

    for (genvar gi = 0; gi < NumInp; gi++) begin : g_age
        logic [AgeW-1:0] r_age;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_age <= '0;
            end else if (en_i) begin
                if (req_valid_i[gi] && !req_ready_i[gi]) begin
                    if (r_age != AgeMax) r_age <= r_age + AgeW'(1);
                end else begin
                    r_age <= '0;
                end
            end
        end

        assign w_starving[gi] = (r_age == AgeMax);

        a_sel_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
            req_valid_i[gi] |-> (32'(req_sel_i[gi]) < NumOut));
    end

    for (genvar go = 0; go < NumOut; go++) begin : g_port
        // An out-of-range select never equals a real bank index, so it targets nobody.
        for (genvar gi = 0; gi < NumInp; gi++) begin : g_tgt
            assign w_tgt[go][gi] = req_valid_i[gi] && (32'(req_sel_i[gi]) == go);
        end

        reqrsp_xbar_prio_port #(
            .NumInp  (NumInp),
            .MstSelW (MstSelW)
        ) u_port (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .i_en          (en_i),
            .i_hs          (gnt_valid_i[go] & gnt_ready_i[go]),
            .i_gnt_idx     (gnt_idx_i[go]),
            .i_starve_mask (w_tgt[go] & w_starving),
            .i_req_mask    (w_tgt[go]),
            .o_rr          (rr_o[go]),
            .o_starve      (starve_o[go])
        );
    end

endmodule

// File: tb/tb_reqrsp_xbar_prio_sched.sv
// Directed bench for reqrsp_xbar_prio_sched with 4 requesters, 2 banks, threshold 3.
module tb_reqrsp_xbar_prio_sched;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][0:0]   req_sel;
    logic [1:0]        gnt_valid;
    logic [1:0]        gnt_ready;
    logic [1:0][1:0]   gnt_idx;
    logic [1:0][1:0]   rr;
    logic [1:0]        starve;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    reqrsp_xbar_prio_sched #(
        .NumInp       (32'd4),
        .NumOut       (32'd2),
        .StarveThresh (32'd3)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .req_valid_i (req_valid),
        .req_ready_i (req_ready),
        .req_sel_i   (req_sel),
        .gnt_valid_i (gnt_valid),
        .gnt_ready_i (gnt_ready),
        .gnt_idx_i   (gnt_idx),
        .rr_o        (rr),
        .starve_o    (starve)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", n_vec, tag, obs, exp);
    endtask

    initial begin
        rst_ni    = 1'b0;
        en_i      = 1'b1;
        req_valid = '0;
        req_ready = '0;
        req_sel   = '0;
        gnt_valid = '0;
        gnt_ready = '0;
        gnt_idx   = '0;
        #12;
        chk("reset_rr", 8'(rr), 8'h00);
        chk("reset_starve", 8'(starve), 8'h00);
        rst_ni = 1'b1;
        tick(1);

        // Round-robin advance and wrap
        gnt_valid = 2'b11; gnt_ready = 2'b11; gnt_idx[0] = 2'd1; gnt_idx[1] = 2'd1;
        tick(1);
        chk("rr0_after_idx1", 8'(rr[0]), 8'd2);
        chk("rr1_after_idx1", 8'(rr[1]), 8'd2);
        gnt_valid = 2'b01; gnt_ready = 2'b01; gnt_idx[0] = 2'd3;
        tick(1);
        chk("rr0_wrap", 8'(rr[0]), 8'd0);
        chk("rr1_hold", 8'(rr[1]), 8'd2);
        gnt_valid = '0; gnt_ready = '0;

        // Starvation of in0 on bank1
        req_valid[0] = 1'b1; req_sel[0] = 1'b1;
        tick(3);
        chk("starve_not_yet", 8'(starve), 8'h00);
        tick(1);
        chk("starve_b1_on", 8'(starve), 8'h02);
        chk("rr1_boost0", 8'(rr[1]), 8'd0);
        gnt_valid[1] = 1'b1; gnt_ready[1] = 1'b1; gnt_idx[1] = 2'd3;
        tick(1);
        chk("boost_other_idx", 8'(starve), 8'h02);
        chk("rr1_still_boost", 8'(rr[1]), 8'd0);
        gnt_idx[1] = 2'd0; req_ready[0] = 1'b1;
        tick(1);
        chk("boost_exit_starve", 8'(starve), 8'h00);
        chk("boost_exit_rr1", 8'(rr[1]), 8'd1);
        gnt_valid = '0; gnt_ready = '0; req_valid[0] = 1'b0; req_ready[0] = 1'b0;
        tick(1);
        chk("after_exit_rr1", 8'(rr[1]), 8'd1);

        // in1 and in3 starve on bank0 together with a grant of idx 2
        req_valid[1] = 1'b1; req_sel[1] = 1'b0;
        req_valid[3] = 1'b1; req_sel[3] = 1'b0;
        tick(3);
        chk("sim_not_yet", 8'(starve), 8'h00);
        gnt_valid[0] = 1'b1; gnt_ready[0] = 1'b1; gnt_idx[0] = 2'd2;
        tick(1);
        chk("sim_boost_idx1", 8'(rr[0]), 8'd1);
        chk("sim_starve_b0", 8'(starve), 8'h01);
        gnt_idx[0] = 2'd1; req_ready[1] = 1'b1;
        tick(1);
        chk("sim_exit_rr0", 8'(rr[0]), 8'd2);
        chk("sim_exit_starve", 8'(starve), 8'h00);
        gnt_valid = '0; gnt_ready = '0; req_ready[1] = 1'b0; req_valid[1] = 1'b0;
        tick(1);
        chk("sim_in3_boost", 8'(rr[0]), 8'd3);
        chk("sim_in3_starve", 8'(starve), 8'h01);
        req_valid[3] = 1'b0;
        tick(1);
        chk("in3_withdraw_rr0", 8'(rr[0]), 8'd2);
        chk("in3_withdraw_starve", 8'(starve), 8'h00);

        // Withdrawal with boost_idx=2 on bank1
        req_valid[2] = 1'b1; req_sel[2] = 1'b1;
        tick(4);
        chk("wd_boost_rr1", 8'(rr[1]), 8'd2);
        chk("wd_boost_starve", 8'(starve), 8'h02);
        req_valid[2] = 1'b0;
        tick(1);
        chk("wd_rr1_prior_ptr", 8'(rr[1]), 8'd1);
        chk("wd_starve_off", 8'(starve), 8'h00);

        // Enable low: stalls and handshakes are dropped
        en_i = 1'b0;
        req_valid[0] = 1'b1; req_sel[0] = 1'b0;
        gnt_valid[0] = 1'b1; gnt_ready[0] = 1'b1; gnt_idx[0] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("en0_no_starve", 8'(starve), 8'h00);
        end
        chk("en0_rr0_frozen", 8'(rr[0]), 8'd2);
        gnt_valid = '0; gnt_ready = '0;
        en_i = 1'b1;
        tick(3);
        chk("en1_age_from_zero", 8'(starve), 8'h00);
        tick(1);
        chk("en1_boost_b0", 8'(starve), 8'h01);
        chk("en1_rr0_idx0", 8'(rr[0]), 8'd0);
        chk("en1_rr1", 8'(rr[1]), 8'd1);

        // Asynchronous reset while bank0 is boosted
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_rr", 8'(rr), 8'h00);
        chk("async_rst_starve", 8'(starve), 8'h00);
        req_valid = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(1);
        chk("post_rst_starve", 8'(starve), 8'h00);
        chk("post_rst_rr", 8'(rr), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
